// File: rtl/uart_rx_fifo_pkg.sv
// Definitions shared by the UART blocks: byte width, default bit period and
// the receiver/transmitter state encodings.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int CLKS_PER_BIT    = 217;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Not reset; occupancy tracking in the parent decides which entries are live.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO, first-word-fall-through; byte strobed in cycle N is at the head in N+1.
// When full, a strobe without a same-cycle pop is dropped and sets sticky Overflow. Option: UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2
`endif
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Rx_Receive,
    input  logic [DATA_WIDTH-1:0]      Rx_Data,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [DATA_WIDTH-1:0]      Out_Data,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Overflow,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    output logic                       Almost_Full,
`endif
    input  logic                       Clear_Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Occupancy comes only from the counter, so equal pointers are never ambiguous.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && Out_Ready;
    assign w_push  = Rx_Receive && (!w_full || w_pop);
    assign w_drop  = Rx_Receive && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            // A new drop outranks a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (Clear_Overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .i_clk   (Clock),
        .i_we    (w_push && !Reset),
        .i_waddr (r_wptr),
        .i_wdata (Rx_Data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic r_almost_full;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= CW'(ALMOST_FULL_LEVEL));
        end
    end

    assign Almost_Full = r_almost_full;
`endif

    assign Out_Valid = !w_empty;
    assign Out_Data  = w_empty ? '0 : w_rdata;
    assign Count     = r_count;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Overflow  = r_overflow;

endmodule
